gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Synchronous up/down counter that keeps a binary count and a registered Gray-code copy of it.
- The Gray output changes by exactly one bit per count step.
- Produces Gray-coded pointers and position codes for consumers that decode them with the team's existing Gray-to-binary decoder, for example across clock domains.
- Encoder end of that Gray-code path: binary in, Gray out.

Parameters:
- WIDTH, 4, bit width of the count, binary output and Gray output (minimum 2).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one step per cycle while high.
- up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of load_bin; takes priority over en.
- load_bin  input  WIDTH  binary value loaded when load=1.
- bin_out  output  WIDTH  registered binary count.
- gray_out  output  WIDTH  registered Gray code of bin_out.
- wrap  output  1  one-cycle pulse marking a count step that wrapped.

Behaviour:
- All outputs are registered and update only on the rising edge of clk. There is no combinational path from any input to any output.
- Reset (rst=1 at a clock edge): bin_out=0, gray_out=0, wrap=0. Reset overrides load and en in the same cycle. Reset asserted mid-count clears the outputs on that edge, and counting resumes from 0 on the first edge after rst falls.
- Priority per edge: rst > load > en > hold.
- Load (load=1):
  - bin_out <= load_bin.
  - gray_out <= load_bin ^ (load_bin >> 1).
  - wrap <= 0.
  - en and up_dn are ignored.
- Count up (en=1, up_dn=1):
  - bin_out <= (bin_out + 1) mod 2^WIDTH.
  - wrap <= 1 only when the old bin_out is all ones; otherwise wrap <= 0.
- Count down (en=1, up_dn=0):
  - bin_out <= (bin_out - 1) mod 2^WIDTH.
  - wrap <= 1 only when the old bin_out is 0; otherwise wrap <= 0.
- Hold (en=0, load=0): bin_out and gray_out keep their values; wrap <= 0.
- Coherence:
  - gray_out is computed from the next binary value, so on every cycle gray_out == bin_out ^ (bin_out >> 1). The two outputs are never one cycle apart.
  - The MSB of gray_out equals the MSB of bin_out.
- Single-bit-change property: on every count step (up or down, including the wrap step) gray_out differs from its previous value in exactly one bit. Load and reset are exempt.
- Latency: 1 clock from en, load or rst to the updated outputs.
- wrap is a pulse. It is never held high across consecutive hold cycles. During continuous wrapping it can be high only on the cycle after a wrap step.
- Direction may change on any cycle. The step always uses the current bin_out, with no extra latency.
- Decoding gray_out with the team's Gray-to-binary decoder must reproduce bin_out on every cycle.

Test Plan:
- Reset and hold:
  - Stimulus: rst=1 for 2 cycles, then rst=0, en=0 for 3 cycles.
  - Required: bin_out=0000, gray_out=0000, wrap=0 throughout.
- Full count up:
  - Stimulus: en=1, up_dn=1 for 16 cycles from 0.
  - Required: gray_out follows 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - Required: wrap=1 only on the 1000→0000 step.
  - Required: exactly one gray bit toggles per cycle.
- Count down and wrap:
  - Stimulus: from bin_out=0000, en=1, up_dn=0 for 2 cycles.
  - Required: bin_out=1111/gray_out=1000 with wrap=1, then bin_out=1110/gray_out=1001 with wrap=0.
- Load priority:
  - Stimulus: load=1, load_bin=1010, en=1, up_dn=1 in the same cycle.
  - Required: bin_out=1010, gray_out=1111, wrap=0.
  - Stimulus: next cycle with load=0.
  - Required: bin_out=1011, gray_out=1110.
- Reset mid-operation:
  - Stimulus: while counting up at bin_out=0110, assert rst=1 together with load=1, load_bin=1111.
  - Required: bin_out=0000, gray_out=0000, wrap=0.
  - Required: after rst falls, the count resumes 0001/0001.
- Direction toggle:
  - Stimulus: at bin_out=0111, alternate up_dn 1,0,1,0 with en=1.
  - Required: bin_out 1000,0111,1000,0111.
  - Required: gray_out 1100,0100,1100,0100.
  - Required: wrap=0 throughout.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy that changes one bit per step.
// Binary in, Gray out: the encoder end of the team's Gray pointer path.
module gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_C      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES_C = {WIDTH{1'b1}};

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] bin_r;
    logic [WIDTH-1:0] gray_r;
    logic             wrap_r;
    logic [WIDTH-1:0] next_bin_s;
    logic             next_wrap_s;

    // Next binary value and wrap flag: load beats count, count beats hold.
    always_comb begin
        next_bin_s  = bin_r;
        next_wrap_s = 1'b0;
        if (load) begin
            next_bin_s  = load_bin;
            next_wrap_s = 1'b0;
        end else if (en) begin
            if (up_dn) begin
                next_bin_s  = bin_r + ONE_C;
                next_wrap_s = (bin_r == ALL_ONES_C);
            end else begin
                next_bin_s  = bin_r - ONE_C;
                next_wrap_s = (bin_r == ZERO_C);
            end
        end else begin
            next_bin_s  = bin_r;
            next_wrap_s = 1'b0;
        end
    end

    // State registers; Gray is encoded from the next binary so both outputs stay coherent.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r  <= ZERO_C;
            gray_r <= ZERO_C;
            wrap_r <= 1'b0;
        end else begin
            bin_r  <= next_bin_s;
            gray_r <= bin2gray(next_bin_s);
            wrap_r <= next_wrap_s;
        end
    end

    assign bin_out  = bin_r;
    assign gray_out = gray_r;
    assign wrap     = wrap_r;

endmodule

// File: tb/tb_gray_counter.sv
// Randomized self-checking bench for gray_counter against an arithmetic reference model
// with a reflected-construction Gray table.
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin_out;
    logic [W-1:0] gray_out;
    logic         wrap;

    int n_checks;
    int n_errors;
    int m_bin;
    int m_wrap;
    int gray_tab [MOD];
    logic [W-1:0] prev_gray;

    gray_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_bin (load_bin),
        .bin_out  (bin_out),
        .gray_out (gray_out),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int gray_decode(input int g);
        int acc;
        int res;
        acc = 0;
        res = 0;
        for (int i = W - 1; i >= 0; i--) begin
            acc = acc ^ ((g >> i) & 1);
            res = res | (acc << i);
        end
        return res;
    endfunction

    // One clock: advance the model with the applied inputs, then compare after the edge.
    task automatic cycle();
        bit stepped;
        stepped = 1'b0;
        prev_gray = gray_out;
        @(posedge clk);
        if (rst) begin
            m_bin  = 0;
            m_wrap = 0;
        end else if (load) begin
            m_bin  = int'(load_bin);
            m_wrap = 0;
        end else if (en) begin
            stepped = 1'b1;
            if (up_dn) begin
                m_wrap = (m_bin == MOD - 1) ? 1 : 0;
                m_bin  = (m_bin + 1) % MOD;
            end else begin
                m_wrap = (m_bin == 0) ? 1 : 0;
                m_bin  = (m_bin + MOD - 1) % MOD;
            end
        end else begin
            m_wrap = 0;
        end
        #1;
        check("bin", int'(bin_out), m_bin);
        check("gray", int'(gray_out), gray_tab[m_bin]);
        check("wrap", int'(wrap), m_wrap);
        check("decode", gray_decode(int'(gray_out)), int'(bin_out));
        if (stepped) begin
            check("onebit", $countones(gray_out ^ prev_gray), 1);
        end
    endtask

    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lb);
        rst      = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_bin = W'(lb);
    endtask

    initial begin
        int size;
        n_checks = 0;
        n_errors = 0;
        m_bin    = 0;
        m_wrap   = 0;
        // Reflected Gray construction: mirror the list and set the next bit on the mirror.
        gray_tab[0] = 0;
        size = 1;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < size; i++) begin
                gray_tab[size + i] = gray_tab[size - 1 - i] | (1 << k);
            end
            size = size * 2;
        end

        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        #2;
        repeat (2) cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
        repeat (3) cycle();
        check("reset_hold_gray", int'(gray_out), 0);

        // Full count up through the wrap.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        repeat (16) cycle();
        check("full_up_end_bin", int'(bin_out), 0);
        check("full_up_end_wrap", int'(wrap), 1);

        // Count down across zero.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0);
        cycle();
        check("down_gray0", int'(gray_out), 8);
        check("down_wrap0", int'(wrap), 1);
        cycle();
        check("down_gray1", int'(gray_out), 9);
        check("down_wrap1", int'(wrap), 0);

        // Load beats enable.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 10);
        cycle();
        check("load_bin", int'(bin_out), 10);
        check("load_gray", int'(gray_out), 15);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        check("after_load_gray", int'(gray_out), 14);

        // Reset beats load mid-count.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5);
        cycle();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        check("pre_rst_bin", int'(bin_out), 6);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 15);
        cycle();
        check("mid_rst_bin", int'(bin_out), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        cycle();
        check("resume_gray", int'(gray_out), 1);

        // Direction toggle around 0111.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 7);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, (i % 2 == 0), 1'b0, 0);
            cycle();
            check("toggle_gray", int'(gray_out), (i % 2 == 0) ? 12 : 4);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(31) == 0), ($urandom_range(3) != 0), $urandom_range(1),
                  ($urandom_range(7) == 0), $urandom_range(MOD - 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
